// File: rtl/ifu_cinst_aligner.sv
`default_nettype none
// ============================================================================
// Module   : ifu_cinst_aligner
// Brief    : Instruction-fetch halfword aligner. Buffers up to four 16-bit
//            halfwords from 32-bit fetch words. It presents one instruction
//            per cycle to decode, either a compressed halfword expanded by an
//            external 16b->32b expander or a 32-bit instruction. A 32-bit
//            instruction may straddle two fetch words.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_cinst_aligner (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        flush,
    // fetch side
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    input  logic [29:0] fetch_pc,
    input  logic        fetch_hoff,
    // compressed-instruction expander
    output logic [15:0] cdec_din,
    input  logic [31:0] cdec_dout,
    input  logic        cdec_legal,
    // decode side
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_instr,
    output logic        ins_is16,
    output logic        ins_illegal,
    output logic [30:0] ins_pc
);

    localparam int unsigned c_DEPTH    = 4;
    localparam logic [2:0]  c_MAX_POST = 3'd2;

    // Halfword storage and bookkeeping
    logic [15:0] r_buf [0:c_DEPTH-1];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic [30:0] r_head_pc;

    // Datapath and control wires
    logic [1:0]  w_rd_ptr_p1;
    logic [1:0]  w_wr_ptr_p1;
    logic [15:0] w_h0;
    logic [15:0] w_h1;
    logic        w_h0_is16;
    logic        w_pop;
    logic [2:0]  w_pop_n;
    logic [2:0]  w_pop_amt;
    logic [2:0]  w_count_post;
    logic        w_push;
    logic [2:0]  w_push_amt;

    assign w_rd_ptr_p1 = r_rd_ptr + 2'd1;
    assign w_wr_ptr_p1 = r_wr_ptr + 2'd1;

    // Head/next halfwords, masked to zero when not buffered so the empty
    // state presents deterministic values to the expander and to decode.
    always_comb begin
        w_h0 = 16'h0000;
        w_h1 = 16'h0000;
        if (r_count != 3'd0) begin
            w_h0 = r_buf[r_rd_ptr];
        end
        if (r_count >= 3'd2) begin
            w_h1 = r_buf[w_rd_ptr_p1];
        end
    end

    // Low two bits of 2'b11 mark a full 32-bit instruction
    assign w_h0_is16 = (w_h0[1:0] != 2'b11);
    assign cdec_din  = w_h0;

    // Instruction presentation; a 32-bit head waits for its second halfword
    always_comb begin
        ins_valid   = 1'b0;
        ins_instr   = {w_h1, w_h0};
        ins_is16    = 1'b0;
        ins_illegal = 1'b0;
        if (w_h0_is16) begin
            ins_valid   = (r_count >= 3'd1);
            ins_instr   = cdec_dout;
            ins_is16    = 1'b1;
            ins_illegal = ~cdec_legal;
        end else begin
            ins_valid   = (r_count >= 3'd2);
        end
    end

    assign ins_pc = r_head_pc;

    // Pop/push sizing. Accept is granted from the occupancy left after this
    // cycle's pop, so a full buffer can still take a word while draining.
    assign w_pop        = ins_valid & ins_ready & ~flush;
    assign w_pop_n      = w_h0_is16 ? 3'd1 : 3'd2;
    assign w_pop_amt    = w_pop ? w_pop_n : 3'd0;
    assign w_count_post = r_count - w_pop_amt;
    assign fetch_ready  = (w_count_post <= c_MAX_POST);
    assign w_push       = fetch_valid & fetch_ready & ~flush;
    assign w_push_amt   = w_push ? (fetch_hoff ? 3'd1 : 3'd2) : 3'd0;

    // Halfword storage writes: upper halfword only for a misaligned target
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_buf[i] <= 16'h0000;
            end
        end else if (w_push) begin
            if (fetch_hoff) begin
                r_buf[r_wr_ptr]    <= fetch_data[31:16];
            end else begin
                r_buf[r_wr_ptr]    <= fetch_data[15:0];
                r_buf[w_wr_ptr_p1] <= fetch_data[31:16];
            end
        end
    end

    // Pointer, occupancy and head-address update; flush empties the buffer
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr  <= 2'd0;
            r_rd_ptr  <= 2'd0;
            r_count   <= 3'd0;
            r_head_pc <= 31'd0;
        end else if (flush) begin
            r_wr_ptr  <= 2'd0;
            r_rd_ptr  <= 2'd0;
            r_count   <= 3'd0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push_amt[1:0];
            r_rd_ptr <= r_rd_ptr + w_pop_amt[1:0];
            r_count  <= w_count_post + w_push_amt;
            // A push into an emptied buffer defines a new head address
            if (w_push && (w_count_post == 3'd0)) begin
                r_head_pc <= {fetch_pc, fetch_hoff};
            end else if (w_pop) begin
                r_head_pc <= r_head_pc + {28'd0, w_pop_n};
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ifu_cinst_aligner.md
IFU_CINST_ALIGNER -- requirements
Module: ifu_cinst_aligner

Interface
REQ-001 SHALL have port clk, in, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_l, in, 1: reset, asynchronous assert, active-low.
REQ-003 SHALL have port flush, in, 1: discard all buffered halfwords and any fetch offered this cycle.
REQ-004 SHALL have port fetch_valid, in, 1: fetch word offered.
REQ-005 SHALL have port fetch_ready, out, 1: aligner accepts fetch word this cycle.
REQ-006 SHALL have port fetch_data, in, 32: little-endian halfwords; [15:0] is at the lower address.
REQ-007 SHALL have port fetch_pc, in, 30 ([31:2]): word address of fetch_data.
REQ-008 SHALL have port fetch_hoff, in, 1: 1 = first valid halfword is [31:16] (misaligned target).
REQ-009 SHALL have port cdec_din, out, 16: halfword driven to the 16b-to-32b expander.
REQ-010 SHALL have port cdec_dout, in, 32: expander result.
REQ-011 SHALL have port cdec_legal, in, 1: expander legality.
REQ-012 SHALL have port ins_valid, out, 1: instruction available to decode.
REQ-013 SHALL have port ins_ready, in, 1: decode consumes instruction.
REQ-014 SHALL have port ins_instr, out, 32: 32-bit instruction (expanded if compressed).
REQ-015 SHALL have port ins_is16, out, 1: instruction came from one halfword.
REQ-016 SHALL have port ins_illegal, out, 1: compressed halfword with cdec_legal=0.
REQ-017 SHALL have port ins_pc, out, 31 ([31:1]): halfword address of instruction.

Function
REQ-018 SHALL hold a 4-entry halfword FIFO (wr ptr, rd ptr, count 0..4, pointers wrap modulo 4) plus head_pc[31:1].
REQ-019 SHALL drive fetch_ready=1 when count<=2 after this cycle's pop, combinationally; fetch_ready SHALL NOT depend on fetch_valid.
REQ-020 On accept (fetch_valid & fetch_ready & !flush), SHALL push 2 halfwords, or only [31:16] when fetch_hoff=1.
REQ-021 On push into an empty FIFO (count==0 after pop), SHALL load head_pc = {fetch_pc, fetch_hoff}.
REQ-022 Head halfword h0 compressed when h0[1:0]!=2'b11; SHALL drive cdec_din=h0 always (0 when count==0).
REQ-023 ins_valid SHALL be 1 when count>=1 and h0 compressed, or count>=2 and h0 not compressed; else 0.
REQ-024 Compressed: ins_instr=cdec_dout, ins_is16=1, ins_illegal=!cdec_legal; non-compressed: ins_instr={h1,h0}, ins_is16=0, ins_illegal=0.
REQ-025 ins_pc SHALL equal head_pc; on pop SHALL advance head_pc by 1 (16b) or 2 (32b) halfwords, wrapping modulo 2^31.
REQ-026 Pop occurs on ins_valid & ins_ready; SHALL remove 1 or 2 halfwords; push and pop in the same cycle SHALL both take effect.
REQ-027 32b instruction with only h0 buffered SHALL hold ins_valid=0 until the next push supplies h1 (straddle across fetch words).
REQ-028 flush SHALL set count=0 next cycle, ignore pop and push that cycle; ins_valid SHALL remain combinational (may be 1 in the flush cycle), decode ignores it.
REQ-029 Outputs ins_* SHALL be stable while ins_valid=1 and ins_ready=0.
REQ-030 Count overflow SHALL be impossible: push allowed only with <=2 entries post-pop.

Reset
REQ-031 rst_l=0 SHALL asynchronously clear count, pointers, head_pc to 0; ins_valid=0, fetch_ready=1, cdec_din=0, ins_instr/ins_is16/ins_illegal/ins_pc derived from the empty state.
REQ-032 Reset mid-operation SHALL discard all buffered halfwords with no partial instruction retained.

Verification
REQ-033 Fetch 0x00014501 pc 0x1000 hoff=0, ins_ready=1 -> two 16b instrs, ins_pc 0x800 then 0x801 (halfword), ins_is16=1.
REQ-034 Fetch 0x00A00093 (addi) -> one instr ins_instr=0x00A00093, ins_is16=0, head_pc +2.
REQ-035 Fetch {0x0093,0x4501} then {0xxxxx,0x00A0} -> 16b at halfword 0, 32b 0x00A00093 straddling, valid only after second push.
REQ-036 Fetch 0x00000000 (illegal compressed) -> ins_valid=1, ins_illegal=1, ins_is16=1.
REQ-037 ins_ready=0 with repeated fetch_valid -> fetch_ready drops when count>2; no halfword lost or duplicated.
REQ-038 flush with count=3 and simultaneous fetch -> next cycle count=0, ins_valid=0; rst_l low mid-stream -> same empty state immediately.
